// File: rtl/bus_master.sv
// Initiator for the multiplexed address/data main bus: one address phase
// followed by a fixed burst of data beats, read or write, per host request.
module bus_master #(
  parameter int unsigned BUSWIDTH = 16,
  parameter int unsigned BURST    = 4
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_rw,
  input  logic [BUSWIDTH-1:0]          req_addr,
  input  logic [BUSWIDTH*BURST-1:0]    req_wdata,
  output logic                         rsp_valid,
  output logic [BUSWIDTH*BURST-1:0]    rsp_rdata,
  output logic                         bus_addr_valid,
  output logic                         bus_rw,
  output logic [BUSWIDTH-1:0]          bus_ad_out,
  output logic                         bus_ad_oe,
  input  logic [BUSWIDTH-1:0]          bus_ad_in,
  output logic                         busy
);

  localparam int unsigned CNT_W = $clog2(BURST) + 1;
  localparam int unsigned DW    = BUSWIDTH * BURST;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, TURN} state_t;

  state_t              state;
  logic                rw_q;
  logic [DW-1:0]       wdata_q;
  logic [DW-1:0]       rd_buf;
  logic [DW-1:0]       rd_next;
  logic [CNT_W-1:0]    beat;
  logic                last_beat;
  logic [BUSWIDTH-1:0] next_word;

  // Beat bookkeeping: word for the following write beat and read buffer with this beat merged in
  always_comb begin
    last_beat = (beat == CNT_W'(BURST - 1));
    next_word = '0;
    rd_next   = rd_buf;
    for (int unsigned i = 0; i < BURST; i++) begin
      if (CNT_W'(i) == beat + CNT_W'(1)) next_word = wdata_q[i*BUSWIDTH +: BUSWIDTH];
      if (CNT_W'(i) == beat)             rd_next[i*BUSWIDTH +: BUSWIDTH] = bus_ad_in;
    end
  end

  // Bus FSM; every output is loaded with its value for the state being entered
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= IDLE;
      rw_q           <= 1'b0;
      wdata_q        <= '0;
      rd_buf         <= '0;
      beat           <= '0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      bus_addr_valid <= 1'b0;
      bus_rw         <= 1'b0;
      bus_ad_out     <= '0;
      bus_ad_oe      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      rsp_valid      <= 1'b0;
      bus_addr_valid <= 1'b0;
      bus_rw         <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            rw_q           <= req_rw;
            wdata_q        <= req_wdata;
            bus_addr_valid <= 1'b1;
            bus_rw         <= req_rw;
            bus_ad_out     <= req_addr;
            bus_ad_oe      <= 1'b1;
            req_ready      <= 1'b0;
            busy           <= 1'b1;
            state          <= ADDR;
          end
        end
        ADDR: begin
          beat       <= '0;
          bus_ad_oe  <= ~rw_q;
          bus_ad_out <= rw_q ? '0 : wdata_q[BUSWIDTH-1:0];
          state      <= DATA;
        end
        DATA: begin
          beat <= beat + CNT_W'(1);
          if (rw_q) rd_buf <= rd_next;
          if (last_beat) begin
            // Release the bus for the turnaround cycle and report completion
            bus_ad_oe  <= 1'b0;
            bus_ad_out <= '0;
            rsp_valid  <= 1'b1;
            if (rw_q) rsp_rdata <= rd_next;
            state      <= TURN;
          end else begin
            bus_ad_oe  <= ~rw_q;
            bus_ad_out <= rw_q ? '0 : next_word;
          end
        end
        TURN: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
